// File: rtl/h80cpu_io_if.sv
// Shared h80 I/O bus: address/command/write data from the CPU, toggle handshake
// (run/done) and read data back from the slave.
interface h80cpu_io_if;
  logic [15:0] addr;
  logic [2:0]  cmd;
  logic        run;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        done;

  modport master (output addr, cmd, run, wr_data, input rd_data, done);
  modport slave  (input addr, cmd, run, wr_data, output rd_data, done);
endinterface

// File: rtl/h80cpu_io.sv
// h80 I/O bus slave: 8N1 UART transmitter at word 0x0000 and status at word 0x0002.
// Writes to a busy transmitter stall the handshake until the current frame ends.
module h80cpu_io #(
  parameter int CLK_FREQ = 27000000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        reset_,
  h80cpu_io_if.slave  bus,
  output logic        uart_txp
);

  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW  = ($clog2(DIV) < 1) ? 1 : $clog2(DIV);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_TX
  } state_t;

  state_t          state_q, state_d;
  logic            done_q, done_d;
  logic [15:0]     rd_data_q, rd_data_d;
  logic [7:0]      pend_byte_q, pend_byte_d;
  logic            tx_busy_q, tx_busy_d;
  logic [9:0]      shift_q, shift_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [3:0]      bit_q, bit_d;

  logic            pending;
  logic            is_txdata;
  logic            is_status;
  logic            is_read;
  logic            is_write;
  logic            byte_op;
  logic            tx_ending;
  logic            tx_ready;
  logic [15:0]     rd_word;
  logic [15:0]     rd_val;
  logic            load;
  logic [7:0]      load_byte;
  logic [9:0]      shift_nxt;

  assign pending   = bus.run ^ done_q;
  assign is_txdata = (bus.addr[15:1] == 15'd0);
  assign is_status = (bus.addr[15:1] == 15'd1);
  assign is_read   = (bus.cmd == 3'd0) || (bus.cmd == 3'd2);
  assign is_write  = (bus.cmd == 3'd1) || (bus.cmd == 3'd3);
  assign byte_op   = bus.cmd[1];

  // The stop bit ends on this edge, so a new byte may be loaded with no idle gap.
  assign tx_ending = tx_busy_q && (baud_q == '0) && (bit_q == 4'd0);
  assign tx_ready  = !tx_busy_q || tx_ending;

  assign rd_word = is_status ? {15'd0, tx_busy_q} : 16'h0000;
  assign rd_val  = byte_op ? {8'h00, (bus.addr[0] ? rd_word[15:8] : rd_word[7:0])} : rd_word;

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_shift
      if (gi == 9) begin : g_fill
        assign shift_nxt[gi] = 1'b1;
      end else begin : g_move
        assign shift_nxt[gi] = shift_q[gi+1];
      end
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    rd_data_d   = rd_data_q;
    pend_byte_d = pend_byte_q;
    load        = 1'b0;
    load_byte   = pend_byte_q;

    case (state_q)
      ST_IDLE: begin
        if (pending) begin
          if (is_read) begin
            rd_data_d = rd_val;
            done_d    = ~done_q;
          end else if (is_write && is_txdata) begin
            if (tx_ready) begin
              load      = 1'b1;
              load_byte = bus.wr_data[7:0];
              done_d    = ~done_q;
            end else begin
              pend_byte_d = bus.wr_data[7:0];
              state_d     = ST_WAIT_TX;
            end
          end else begin
            done_d = ~done_q;
          end
        end
      end
      ST_WAIT_TX: begin
        if (tx_ready) begin
          load      = 1'b1;
          load_byte = pend_byte_q;
          done_d    = ~done_q;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_d   = shift_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    tx_busy_d = tx_busy_q;

    if (load) begin
      shift_d   = {1'b1, load_byte, 1'b0};
      baud_d    = CW'(DIV - 1);
      bit_d     = 4'd9;
      tx_busy_d = 1'b1;
    end else if (tx_busy_q) begin
      if (baud_q == '0) begin
        baud_d = CW'(DIV - 1);
        if (bit_q == 4'd0) begin
          tx_busy_d = 1'b0;
          shift_d   = '1;
        end else begin
          shift_d = shift_nxt;
          bit_d   = bit_q - 4'd1;
        end
      end else begin
        baud_d = baud_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      rd_data_q   <= 16'h0000;
      pend_byte_q <= 8'h00;
      tx_busy_q   <= 1'b0;
      shift_q     <= '1;
      baud_q      <= '0;
      bit_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      rd_data_q   <= rd_data_d;
      pend_byte_q <= pend_byte_d;
      tx_busy_q   <= tx_busy_d;
      shift_q     <= shift_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
    end
  end

  assign bus.done    = done_q;
  assign bus.rd_data = rd_data_q;
  assign uart_txp    = shift_q[0];

endmodule

// File: tb/tb_h80cpu_io.sv
// Directed bench for h80cpu_io: read data and frame bytes are queued as expectations
// when requests are issued and checked when the DUT answers or a frame completes.
module tb_h80cpu_io;

  typedef struct {
    logic [7:0] b;
    int         start;
  } frame_t;

  logic clk = 1'b0;
  logic reset_;
  logic uart_txp;
  logic mon_en;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  logic [15:0] rd_q[$];
  frame_t      frame_q[$];

  h80cpu_io_if bus ();

  h80cpu_io #(.CLK_FREQ(1600), .BAUD(100)) dut (
    .clk      (clk),
    .reset_   (reset_),
    .bus      (bus.slave),
    .uart_txp (uart_txp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [2:0] c, input logic [15:0] a, input logic [15:0] wd,
                     input int max_wait, output int lat);
    @(negedge clk);
    bus.cmd     = c;
    bus.addr    = a;
    bus.wr_data = wd;
    bus.run     = ~bus.run;
    lat = -1;
    for (int i = 1; i <= max_wait; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === bus.run) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic rd(input string tag, input logic [2:0] c, input logic [15:0] a,
                    input logic [15:0] exp);
    int lat;
    rd_q.push_back(exp);
    req(c, a, 16'h0000, 4, lat);
    chk({tag, " latency"}, lat, 1);
    chk(tag, bus.rd_data, rd_q.pop_front());
  endtask

  task automatic wr(input string tag, input logic [2:0] c, input logic [15:0] a,
                    input logic [15:0] wd, input int exp_lat, input bit sends);
    int lat;
    req(c, a, wd, 200, lat);
    chk({tag, " latency"}, lat, exp_lat);
    if (sends) frame_q.push_back('{wd[7:0], cyc});
  endtask

  // UART monitor: samples mid-bit, 16 cycles per bit.
  initial begin
    logic [9:0] bits;
    int s;
    frame_t f;
    wait (mon_en === 1'b1);
    forever begin
      @(posedge clk);
      #1;
      if (uart_txp === 1'b0) begin
        s = cyc;
        for (int k = 0; k < 10; k++) begin
          repeat ((k == 0) ? 8 : 16) @(posedge clk);
          #1;
          bits[k] = uart_txp;
        end
        repeat (7) @(posedge clk);
        chk("frame queued", {31'd0, frame_q.size() > 0}, 1);
        if (frame_q.size() > 0) begin
          f = frame_q.pop_front();
          $display("[TB] frame byte %02h start cycle %0d", bits[8:1], s);
          chk("frame data", {24'd0, bits[8:1]}, {24'd0, f.b});
          chk("start bit", {31'd0, bits[0]}, 0);
          chk("stop bit", {31'd0, bits[9]}, 1);
          chk("frame start", s, f.start);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int lows;
    bus.addr    = 16'h0000;
    bus.cmd     = 3'd0;
    bus.run     = 1'b0;
    bus.wr_data = 16'h0000;
    reset_      = 1'b0;
    mon_en      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_ = 1'b1;
    repeat (2) @(posedge clk);

    // Reset in the middle of a frame with done=1 and rd_data=1
    wr("t1 write", 3'd3, 16'h0000, 16'h005A, 1, 1'b0);
    rd("t1 status a", 3'd0, 16'h0002, 16'h0001);
    rd("t1 status b", 3'd0, 16'h0002, 16'h0001);
    @(negedge clk);
    #2;
    chk("t1 line before reset", {31'd0, uart_txp}, 0);
    reset_  = 1'b0;
    bus.run = 1'b0;
    #1;
    chk("t1 reset txp", {31'd0, uart_txp}, 1);
    chk("t1 reset done", {31'd0, bus.done}, 0);
    chk("t1 reset rd_data", {16'd0, bus.rd_data}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_ = 1'b1;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (uart_txp !== 1'b1) lows++;
    end
    chk("t1 idle after reset", lows, 0);
    mon_en = 1'b1;

    // Single byte frame
    wr("t2 write_b", 3'd3, 16'h0000, 16'h1248, 1, 1'b1);
    repeat (170) @(posedge clk);

    // Back-to-back writes: second one stalls until the first frame ends
    wr("t3 first", 3'd3, 16'h0000, 16'h0048, 1, 1'b1);
    wr("t3 second", 3'd3, 16'h0000, 16'h0065, 160, 1'b1);

    // Status during and after a frame, reserved commands
    rd("t4 status busy", 3'd0, 16'h0002, 16'h0001);
    req(3'd5, 16'h0002, 16'h0000, 4, lat);
    chk("t4 reserved latency", lat, 1);
    chk("t4 reserved rd_data", {16'd0, bus.rd_data}, 16'h0001);
    wr("t4 reserved to txdata", 3'd7, 16'h0000, 16'h0077, 1, 1'b0);
    rd("t4 read_b 0003", 3'd2, 16'h0003, 16'h0000);
    rd("t4 read_b 0002", 3'd2, 16'h0002, 16'h0001);
    repeat (170) @(posedge clk);
    rd("t4 status idle", 3'd0, 16'h0002, 16'h0000);

    // Unmapped addresses
    rd("t5 read unmapped", 3'd0, 16'h1234, 16'h0000);
    wr("t5 write unmapped", 3'd1, 16'h1234, 16'h0055, 1, 1'b0);
    wr("t5 write status", 3'd1, 16'h0002, 16'h0066, 1, 1'b0);
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (uart_txp !== 1'b1) lows++;
    end
    chk("t5 line idle", lows, 0);

    // write_w sends only the low byte
    wr("t6 write_w", 3'd1, 16'h0000, 16'hAB41, 1, 1'b1);
    rd("t6 read txdata", 3'd0, 16'h0000, 16'h0000);
    repeat (180) @(posedge clk);
    chk("frames outstanding", frame_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
